// File: rtl/mmcm_lockmon_pkg.sv
// Shared types and helpers for the MMCM lock monitor and its sub-blocks.
package mmcm_lockmon_pkg;

  typedef enum logic [2:0] {
    PULSE,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // Bits needed to hold the largest of the three cycle parameters.
  function automatic int cnt_width(input int pulse_cycles,
                                   input int timeout_cycles,
                                   input int stable_cycles);
    int m;
    m = pulse_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mmcm_lock_monitor_sync_2ff.sv
// Generic two-flop synchroniser, asynchronous active-high reset to zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back capture stages to let metastability resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmcm_lock_monitor.sv
// MMCM reset/lock sequencer running on the free-running reference clock.
// Pulses the MMCM reset, waits for lock with timeout/retry, qualifies lock
// for a stable window, then releases sys_reset. The FSM state is exported on
// the debug output 'state'.
// Build option: LOCKMON_LOSS_CNT_EN enables the lock-loss counter; without it
// loss_cnt is tied to zero.
module mmcm_lock_monitor
  import mmcm_lockmon_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               locked_in,
  input  logic               restart,
  output logic               mmcm_reset,
  output logic               sys_reset,
  output logic               lock_ok,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt,
  output state_t             state
);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] MAX_R        = RETRY_W'(MAX_RETRIES);

  logic               lk;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [RETRY_W-1:0] retry_n;
  logic [RETRY_W-1:0] retry_sat;
  state_t             state_n;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (locked_in),
    .q   (lk)
  );

  assign retry_sat = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_W'(1);

  // Next-state, shared cycle counter and retry bookkeeping; restart overrides all.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry_cnt;
    if (restart) begin
      state_n = PULSE;
      cnt_n   = '0;
    end else begin
      case (state)
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            cnt_n   = '0;
            state_n = WAIT_LOCK;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            cnt_n   = '0;
            state_n = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_n   = '0;
            retry_n = retry_sat;
            if ((MAX_RETRIES != 0) && (retry_sat == MAX_R)) state_n = FAIL;
            else                                              state_n = PULSE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lk) begin
            cnt_n   = '0;
            state_n = PULSE;
          end else if (cnt == STABLE_LAST) begin
            cnt_n   = '0;
            state_n = RUN;
            retry_n = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            cnt_n   = '0;
            state_n = PULSE;
          end
        end
        FAIL: begin
          cnt_n = '0;
        end
        default: begin
          cnt_n   = '0;
          state_n = PULSE;
        end
      endcase
    end
  end

  // State register plus Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PULSE;
      cnt        <= '0;
      retry_cnt  <= '0;
      mmcm_reset <= 1'b1;
      sys_reset  <= 1'b1;
      lock_ok    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retry_cnt  <= retry_n;
      mmcm_reset <= (state_n == PULSE) || (state_n == FAIL);
      sys_reset  <= (state_n != RUN);
      lock_ok    <= (state_n == RUN);
      fail       <= (state_n == FAIL);
    end
  end

`ifdef LOCKMON_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = (state == RUN) && !lk && !restart;

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        loss_cnt <= '0;
    else if (loss_evt && loss_cnt != '1) loss_cnt <= loss_cnt + LOSS_W'(1);
  end
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_mmcm_lock_monitor.sv
// Bench for mmcm_lock_monitor: a segment table with hand-derived expected
// outputs, an async-reset sequence, and randomized locked_in/restart traffic
// checked each cycle against a phase/elapsed-time reference model.
module tb_mmcm_lock_monitor;
  import mmcm_lockmon_pkg::*;

  localparam int P  = 4;
  localparam int T  = 40;
  localparam int S  = 20;
  localparam int MR = 3;
  localparam int CW = cnt_width(P, T, S);
`ifdef LOCKMON_LOSS_CNT_EN
  localparam bit LOSS_ON = 1'b1;
`else
  localparam bit LOSS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked_in = 1'b0;
  logic       restart = 1'b0;
  logic       mmcm_reset, sys_reset, lock_ok, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  state_t     dut_state;

  int checks = 0;
  int errors = 0;

  mmcm_lock_monitor #(
    .RST_PULSE_CYCLES    (P),
    .LOCK_TIMEOUT_CYCLES (T),
    .STABLE_CYCLES       (S),
    .MAX_RETRIES         (MR),
    .CNT_W               (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .locked_in  (locked_in),
    .restart    (restart),
    .mmcm_reset (mmcm_reset),
    .sys_reset  (sys_reset),
    .lock_ok    (lock_ok),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state      (dut_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: phase + cycles spent in phase, lock seen two edges late.
  state_t m_st;
  int     m_t;
  int     m_retry;
  int     m_loss;
  bit     m_lk_q[$];

  task automatic model_reset();
    m_st = PULSE; m_t = 0; m_retry = 0; m_loss = 0;
    m_lk_q = {1'b0, 1'b0};
  endtask

  task automatic enter(input state_t s);
    m_st = s; m_t = 0;
  endtask

  task automatic model_edge(input bit lkin, input bit rs);
    bit lk;
    lk = m_lk_q.pop_front();
    m_lk_q.push_back(lkin);
    m_t++;
    if (rs) enter(PULSE);
    else begin
      case (m_st)
        PULSE:     if (m_t == P) enter(WAIT_LOCK);
        WAIT_LOCK: begin
          if (lk) enter(STABLE);
          else if (m_t == T) begin
            if (m_retry < 15) m_retry++;
            if (MR != 0 && m_retry == MR) enter(FAIL);
            else enter(PULSE);
          end
        end
        STABLE: begin
          if (!lk) enter(PULSE);
          else if (m_t == S) begin enter(RUN); m_retry = 0; end
        end
        RUN: begin
          if (!lk) begin
            if (m_loss < 255) m_loss++;
            enter(PULSE);
          end
        end
        default: ;
      endcase
    end
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("state",      8'(dut_state),  8'(m_st));
    chk("mmcm_reset", 8'(mmcm_reset), 8'(m_st == PULSE || m_st == FAIL));
    chk("sys_reset",  8'(sys_reset),  8'(m_st != RUN));
    chk("lock_ok",    8'(lock_ok),    8'(m_st == RUN));
    chk("fail",       8'(fail),       8'(m_st == FAIL));
    chk("retry_cnt",  8'(retry_cnt),  8'(m_retry));
    chk("loss_cnt",   8'(loss_cnt),   LOSS_ON ? 8'(m_loss) : 8'd0);
  endtask

  // Driver: apply inputs for one clock, step the model, check after the edge.
  task automatic step(input bit lk, input bit rs);
    locked_in = lk;
    restart   = rs;
    @(posedge clk);
    model_edge(lk, rs);
    #1 check_model();
    @(negedge clk);
    restart = 1'b0;
  endtask

  typedef struct {
    bit         lk;
    bit         rs;
    int         n;
    state_t     st;
    bit         mr, sr, ok, fl;
    logic [3:0] rc;
    logic [7:0] lc;
  } seg_t;

  seg_t tbl[$];

  task automatic add(input bit lk, input bit rs, input int n, input state_t st,
                     input bit mr, input bit sr, input bit ok, input bit fl,
                     input logic [3:0] rc, input logic [7:0] lc);
    seg_t s;
    s.lk = lk; s.rs = rs; s.n = n; s.st = st;
    s.mr = mr; s.sr = sr; s.ok = ok; s.fl = fl; s.rc = rc; s.lc = lc;
    tbl.push_back(s);
  endtask

  initial begin
    logic [7:0] l1;
    l1 = LOSS_ON ? 8'd1 : 8'd0;
    //   lk rs n        state      mr sr ok fl rc lc
    add(0, 0, P,       WAIT_LOCK, 0, 1, 0, 0, 0, 0);
    add(0, 0, T,       PULSE,     1, 1, 0, 0, 1, 0);
    add(0, 0, P+T,     PULSE,     1, 1, 0, 0, 2, 0);
    add(0, 0, P+T,     FAIL,      1, 1, 0, 1, 3, 0);
    add(0, 0, 10,      FAIL,      1, 1, 0, 1, 3, 0);
    add(0, 1, 1,       PULSE,     1, 1, 0, 0, 3, 0);
    add(0, 0, P,       WAIT_LOCK, 0, 1, 0, 0, 3, 0);
    add(1, 0, S+2,     STABLE,    0, 1, 0, 0, 3, 0);
    add(1, 0, 1,       RUN,       0, 0, 1, 0, 0, 0);
    add(1, 0, 10,      RUN,       0, 0, 1, 0, 0, 0);
    add(0, 0, 1,       RUN,       0, 0, 1, 0, 0, 0);
    add(1, 0, 1,       RUN,       0, 0, 1, 0, 0, 0);
    add(1, 0, 1,       PULSE,     1, 1, 0, 0, 0, l1);
    add(1, 0, P,       WAIT_LOCK, 0, 1, 0, 0, 0, l1);
    add(1, 0, 1,       STABLE,    0, 1, 0, 0, 0, l1);
    add(1, 0, 10,      STABLE,    0, 1, 0, 0, 0, l1);
    add(0, 0, 2,       STABLE,    0, 1, 0, 0, 0, l1);
    add(1, 0, 1,       PULSE,     1, 1, 0, 0, 0, l1);
    add(1, 0, P+1+S,   RUN,       0, 0, 1, 0, 0, l1);
    add(0, 0, 2,       RUN,       0, 0, 1, 0, 0, l1);
    add(0, 1, 1,       PULSE,     1, 1, 0, 0, 0, l1);
    add(0, 0, P,       WAIT_LOCK, 0, 1, 0, 0, 0, l1);
    add(0, 0, T-1,     WAIT_LOCK, 0, 1, 0, 0, 0, l1);
    add(0, 1, 1,       PULSE,     1, 1, 0, 0, 0, l1);
    add(0, 0, P+T,     PULSE,     1, 1, 0, 0, 1, l1);
    add(1, 0, P+1+S,   RUN,       0, 0, 1, 0, 0, l1);

    // Reset state while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",      8'(dut_state),  8'(PULSE));
    chk("rst_mmcm_reset", 8'(mmcm_reset), 8'd1);
    chk("rst_sys_reset",  8'(sys_reset),  8'd1);
    chk("rst_lock_ok",    8'(lock_ok),    8'd0);
    chk("rst_fail",       8'(fail),       8'd0);
    chk("rst_retry_cnt",  8'(retry_cnt),  8'd0);
    chk("rst_loss_cnt",   loss_cnt,       8'd0);
    reset = 1'b0;
    model_reset();

    // Table-driven segments
    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) step(tbl[i].lk, tbl[i].rs);
      chk($sformatf("seg%0d_state", i), 8'(dut_state),  8'(tbl[i].st));
      chk($sformatf("seg%0d_mmcm", i),  8'(mmcm_reset), 8'(tbl[i].mr));
      chk($sformatf("seg%0d_sys", i),   8'(sys_reset),  8'(tbl[i].sr));
      chk($sformatf("seg%0d_ok", i),    8'(lock_ok),    8'(tbl[i].ok));
      chk($sformatf("seg%0d_fail", i),  8'(fail),       8'(tbl[i].fl));
      chk($sformatf("seg%0d_retry", i), 8'(retry_cnt),  8'(tbl[i].rc));
      chk($sformatf("seg%0d_loss", i),  loss_cnt,       tbl[i].lc);
    end

    // Async reset asserted mid-RUN between clock edges
    #2 reset = 1'b1;
    #1;
    chk("arst_state",      8'(dut_state),  8'(PULSE));
    chk("arst_mmcm_reset", 8'(mmcm_reset), 8'd1);
    chk("arst_sys_reset",  8'(sys_reset),  8'd1);
    chk("arst_lock_ok",    8'(lock_ok),    8'd0);
    chk("arst_retry_cnt",  8'(retry_cnt),  8'd0);
    chk("arst_loss_cnt",   loss_cnt,       8'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Randomized lock waveform with occasional restart pulses
    for (int blk = 0; blk < 120; blk++) begin
      bit v;
      int len;
      v   = ($urandom_range(0, 9) < 7);
      len = $urandom_range(1, 70);
      for (int j = 0; j < len; j++) step(v, $urandom_range(0, 63) == 0);
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmcm_lock_monitor.md
Name: mmcm_lock_monitor

Overview:
- Upstream controller for the MMCM clock wrapper. Drives the wrapper's `reset` input and consumes its `locked` output.
- Issues a minimum-width MMCM reset pulse, then waits for lock with a timeout and retries on failure.
- Requires lock to stay stable for a qualification window before releasing `sys_reset` to the generated-clock domains.
- Runs on the free-running board reference clock, never on an MMCM output.

Parameters:
- RST_PULSE_CYCLES, 16, MMCM reset pulse width in clk cycles (min 1).
- LOCK_TIMEOUT_CYCLES, 65536, cycles in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024, consecutive locked cycles required before `sys_reset` deasserts.
- MAX_RETRIES, 7, failed attempts allowed before FAIL; 0 = retry forever.
- CNT_W, 17, width of the shared cycle counter; must hold the largest of the three cycle parameters.

Ports:
- clk  input  1  free-running reference clock.
- reset  input  1  asynchronous, active-high reset.
- locked_in  input  1  MMCM `locked`, asynchronous to clk; synchronised internally.
- restart  input  1  single-cycle pulse that forces a full re-lock sequence.
- mmcm_reset  output  1  drives the MMCM `reset`, active-high.
- sys_reset  output  1  active-high reset for downstream logic, released only after stable lock.
- lock_ok  output  1  high while in RUN.
- fail  output  1  sticky; high in FAIL.
- retry_cnt  output  4  failed lock attempts since the last successful RUN entry; saturates at 15.
- loss_cnt  output  8  lock losses observed in RUN; saturating.

Behaviour:
- Synchronisation: `locked_in` passes through a 2-flop synchroniser; `lk` is the synchronised value. Total latency is 2 cycles.
- Reset values:
  - state = PULSE, cnt = 0
  - mmcm_reset = 1, sys_reset = 1
  - lock_ok = 0, fail = 0
  - retry_cnt = 0, loss_cnt = 0
  - synchroniser flops = 0
- All outputs are registered. No combinational path from any input to any output.
- PULSE:
  - mmcm_reset = 1, sys_reset = 1.
  - cnt increments each cycle.
  - When cnt == RST_PULSE_CYCLES-1: clear cnt, go to WAIT_LOCK.
- WAIT_LOCK:
  - mmcm_reset = 0, sys_reset = 1.
  - If lk = 1: clear cnt, go to STABLE.
  - Else if cnt == LOCK_TIMEOUT_CYCLES-1: retry_cnt += 1 (saturating). If MAX_RETRIES != 0 and the new retry_cnt == MAX_RETRIES, go to FAIL; otherwise go to PULSE.
  - Else cnt += 1.
- STABLE:
  - sys_reset = 1.
  - If lk = 0: clear cnt, go to PULSE. This does not count as a retry.
  - If cnt == STABLE_CYCLES-1 with lk = 1: go to RUN, clear retry_cnt.
- RUN:
  - sys_reset = 0, lock_ok = 1.
  - If lk = 0: loss_cnt += 1 (saturating at 255), go to PULSE. mmcm_reset and sys_reset assert on the next clk edge.
- FAIL:
  - mmcm_reset = 1, sys_reset = 1, fail = 1.
  - Leaves only on `restart` or `reset`.
- restart:
  - In any state: go to PULSE, clear cnt, clear fail. retry_cnt and loss_cnt are kept.
  - restart on the same cycle as a timeout or lock-loss transition: restart wins, no retry_cnt/loss_cnt increment.
- Asynchronous reset mid-sequence: all state returns to reset values immediately. mmcm_reset and sys_reset assert asynchronously, with no glitch-low.
- Outputs are Moore: each is a function of the registered state only.

Optional Feature:
- Macro: LOCKMON_LOSS_CNT_EN.
- Defined: loss_cnt is implemented as above.
- Undefined: the loss_cnt register is removed and the port is tied to 8'd0. All other behaviour is identical.

Decomposition:
- Shared package mmcm_lockmon_pkg:
  - state enum {PULSE, WAIT_LOCK, STABLE, RUN, FAIL}
  - RETRY_W = 4, LOSS_W = 8
  - a function returning the counter width (clog2 of the maximum cycle parameter)
- Sub-module sync_2ff: generic 2-flop synchroniser with async active-high reset, reset value 0. Reused by the clock-domain crossing logic downstream.

Test Plan:
- Reset release, locked_in held 0: mmcm_reset high for exactly 16 cycles, low for 65536, then high again; retry_cnt = 1.
- locked_in rises 100 cycles into WAIT_LOCK and stays high: sys_reset falls 2+1024 cycles after the rise (±1); lock_ok = 1; retry_cnt = 0.
- In RUN, locked_in drops for 1 cycle: loss_cnt = 1; mmcm_reset asserts 3 cycles after the drop; full PULSE/WAIT_LOCK/STABLE sequence repeats.
- locked_in never asserts, MAX_RETRIES = 3: fail = 1 after 3 timeouts; mmcm_reset stays 1. A restart pulse clears fail and a new 16-cycle pulse begins.
- locked_in toggles during STABLE at cycle 500: returns to PULSE; sys_reset never deasserts; retry_cnt unchanged.
- Async reset asserted mid-RUN, between clk edges: sys_reset and mmcm_reset go 1 before the next edge; state = PULSE. With LOCKMON_LOSS_CNT_EN undefined, loss_cnt reads 0 throughout.
